cd_initiator_seq: RTL and testbench

CD_INITIATOR_SEQ -- requirements
Module: cd_initiator_seq

---
 rtl/cd_initiator_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_cd_initiator_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_initiator_seq.sv
// cd_initiator_seq: bus initiator sequencer. Selects the drive, sends the
// command bytes from a 12-entry buffer, streams data-in bytes out through a
// valid/ready port, captures the status and message bytes, and can pulse a
// bus reset on request.
// Build option: define CD_INITIATOR_SEL_TIMEOUT_EN to give up on selection
// after SEL_TIMEOUT cycles without BSY; otherwise selection waits forever.
module cd_initiator_seq #(
   parameter int SEL_TIMEOUT = 1000,
   parameter int RST_CYCLES  = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_wr,
   input  logic [3:0] i_wr_addr,
   input  logic [7:0] i_wr_data,
   input  logic [3:0] i_cmd_len,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic       i_bsy,
   input  logic       i_req,
   input  logic       i_msg,
   input  logic       i_cd,
   input  logic       i_io,
   input  logic [7:0] i_db,
   output logic [7:0] o_db,
   output logic       o_sel,
   output logic       o_ack,
   output logic       o_rst,
   output logic       o_din_valid,
   output logic [7:0] o_din_data,
   input  logic       i_din_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_status,
   output logic [7:0] o_message,
   output logic       o_timeout
);

   // Both counters are one cycle short of their length, so zero is illegal.
   if (SEL_TIMEOUT < 1 || RST_CYCLES < 1) begin : gBadParam
      $error("cd_initiator_seq: SEL_TIMEOUT and RST_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, SELECT, XFER, ACK_HOLD, DIN_WAIT, BUS_RESET} state_t;

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

   state_t         state, stateNext;
   logic [7:0]     cmdBuf [0:11];
   logic [3:0]     cmdLen, cmdLenNext, byteIdx, byteIdxNext;
   logic [RCW-1:0] rstCnt, rstCntNext;
   logic [7:0]     dbNext, dinDataNext, statusNext, messageNext;
   logic           selNext, ackNext, rstNext, dinValidNext, busyNext, doneNext;
   logic           phValid, phCommand, phDataIn, phStatus, phMessage;

`ifdef CD_INITIATOR_SEL_TIMEOUT_EN
   localparam int STW = (SEL_TIMEOUT > 1) ? $clog2(SEL_TIMEOUT) : 1;
   localparam logic [STW-1:0] SEL_LAST = STW'(SEL_TIMEOUT - 1);
   logic [STW-1:0] selCnt, selCntNext;
   logic           timeoutReg, timeoutNext;
   assign o_timeout = timeoutReg;
`else
   assign o_timeout = 1'b0;
`endif

   // Phase lines are only meaningful while the drive holds BSY and REQ.
   assign phValid   = i_bsy & i_req;
   assign phCommand = phValid & ~i_msg &  i_cd & ~i_io;
   assign phDataIn  = phValid & ~i_msg & ~i_cd &  i_io;
   assign phStatus  = phValid & ~i_msg &  i_cd &  i_io;
   assign phMessage = phValid &  i_msg &  i_cd &  i_io;

   // Command buffer write port, open in every state; contents are not reset.
   always_ff @(posedge i_clk) begin
      if (i_wr && i_wr_addr < 4'd12) cmdBuf[i_wr_addr] <= i_wr_data;
   end

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      stateNext    = state;
      cmdLenNext   = cmdLen;
      byteIdxNext  = byteIdx;
      rstCntNext   = rstCnt;
      dbNext       = o_db;
      selNext      = o_sel;
      ackNext      = o_ack;
      rstNext      = o_rst;
      dinValidNext = o_din_valid;
      dinDataNext  = o_din_data;
      busyNext     = o_busy;
      doneNext     = 1'b0;
      statusNext   = o_status;
      messageNext  = o_message;
`ifdef CD_INITIATOR_SEL_TIMEOUT_EN
      selCntNext   = selCnt;
      timeoutNext  = timeoutReg;
`endif
      if (i_abort) begin
         // Abort wins over everything, including a start in the same cycle.
         stateNext    = BUS_RESET;
         selNext      = 1'b0;
         ackNext      = 1'b0;
         dinValidNext = 1'b0;
         rstNext      = 1'b1;
         rstCntNext   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start && i_cmd_len != 4'd0 && i_cmd_len <= 4'd12) begin
                  stateNext   = SELECT;
                  cmdLenNext  = i_cmd_len;
                  byteIdxNext = 4'd0;
                  selNext     = 1'b1;
                  busyNext    = 1'b1;
`ifdef CD_INITIATOR_SEL_TIMEOUT_EN
                  selCntNext  = '0;
                  timeoutNext = 1'b0;
`endif
               end
            end
            SELECT: begin
               if (i_bsy) begin
                  selNext   = 1'b0;
                  stateNext = XFER;
`ifdef CD_INITIATOR_SEL_TIMEOUT_EN
               end else if (selCnt == SEL_LAST) begin
                  selNext     = 1'b0;
                  timeoutNext = 1'b1;
                  doneNext    = 1'b1;
                  busyNext    = 1'b0;
                  stateNext   = IDLE;
               end else begin
                  selCntNext = selCnt + 1'b1;
`endif
               end
            end
            XFER: begin
               if (!i_bsy) begin
                  // Drive released the bus: the sequence is over either way.
                  doneNext  = 1'b1;
                  busyNext  = 1'b0;
                  stateNext = IDLE;
               end else if (phCommand) begin
                  // Past the programmed length the drive gets zero padding.
                  if (byteIdx < cmdLen) begin
                     dbNext      = cmdBuf[byteIdx];
                     byteIdxNext = byteIdx + 4'd1;
                  end else begin
                     dbNext = 8'h00;
                  end
                  ackNext   = 1'b1;
                  stateNext = ACK_HOLD;
               end else if (phDataIn) begin
                  dinDataNext  = i_db;
                  dinValidNext = 1'b1;
                  stateNext    = DIN_WAIT;
               end else if (phStatus) begin
                  statusNext = i_db;
                  ackNext    = 1'b1;
                  stateNext  = ACK_HOLD;
               end else if (phMessage) begin
                  messageNext = i_db;
                  ackNext     = 1'b1;
                  stateNext   = ACK_HOLD;
               end
            end
            DIN_WAIT: begin
               if (i_din_ready) begin
                  dinValidNext = 1'b0;
                  ackNext      = 1'b1;
                  stateNext    = ACK_HOLD;
               end
            end
            ACK_HOLD: begin
               if (!i_req) begin
                  ackNext   = 1'b0;
                  stateNext = XFER;
               end
            end
            BUS_RESET: begin
               if (rstCnt == RST_LAST) begin
                  rstNext   = 1'b0;
                  busyNext  = 1'b0;
                  stateNext = IDLE;
               end else begin
                  rstCntNext = rstCnt + 1'b1;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         cmdLen      <= 4'd0;
         byteIdx     <= 4'd0;
         rstCnt      <= '0;
         o_db        <= 8'h00;
         o_sel       <= 1'b0;
         o_ack       <= 1'b0;
         o_rst       <= 1'b0;
         o_din_valid <= 1'b0;
         o_din_data  <= 8'h00;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_status    <= 8'h00;
         o_message   <= 8'h00;
`ifdef CD_INITIATOR_SEL_TIMEOUT_EN
         selCnt      <= '0;
         timeoutReg  <= 1'b0;
`endif
      end else begin
         state       <= stateNext;
         cmdLen      <= cmdLenNext;
         byteIdx     <= byteIdxNext;
         rstCnt      <= rstCntNext;
         o_db        <= dbNext;
         o_sel       <= selNext;
         o_ack       <= ackNext;
         o_rst       <= rstNext;
         o_din_valid <= dinValidNext;
         o_din_data  <= dinDataNext;
         o_busy      <= busyNext;
         o_done      <= doneNext;
         o_status    <= statusNext;
         o_message   <= messageNext;
`ifdef CD_INITIATOR_SEL_TIMEOUT_EN
         selCnt      <= selCntNext;
         timeoutReg  <= timeoutNext;
`endif
      end
   end

endmodule

// File: tb/tb_cd_initiator_seq.sv
// Directed bench for cd_initiator_seq: plays the drive side of the bus by hand
// and compares every output against hand-computed values.
module tb_cd_initiator_seq;

   localparam int SEL_TIMEOUT = 20;
   localparam int RST_CYCLES  = 16;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_wr;
   logic [3:0] i_wr_addr;
   logic [7:0] i_wr_data;
   logic [3:0] i_cmd_len;
   logic       i_start, i_abort;
   logic       i_bsy, i_req, i_msg, i_cd, i_io;
   logic [7:0] i_db;
   logic [7:0] o_db;
   logic       o_sel, o_ack, o_rst;
   logic       o_din_valid;
   logic [7:0] o_din_data;
   logic       i_din_ready;
   logic       o_busy, o_done;
   logic [7:0] o_status, o_message;
   logic       o_timeout;

   int nChecks = 0;
   int nErrors = 0;

   cd_initiator_seq #(.SEL_TIMEOUT(SEL_TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_wr(i_wr), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_cmd_len(i_cmd_len), .i_start(i_start), .i_abort(i_abort),
      .i_bsy(i_bsy), .i_req(i_req), .i_msg(i_msg), .i_cd(i_cd), .i_io(i_io),
      .i_db(i_db), .o_db(o_db), .o_sel(o_sel), .o_ack(o_ack), .o_rst(o_rst),
      .o_din_valid(o_din_valid), .o_din_data(o_din_data), .i_din_ready(i_din_ready),
      .o_busy(o_busy), .o_done(o_done), .o_status(o_status), .o_message(o_message),
      .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic writeBuf(input logic [3:0] addr, input logic [7:0] data);
      i_wr = 1'b1; i_wr_addr = addr; i_wr_data = data;
      step();
      i_wr = 1'b0;
   endtask

   task automatic startCmd(input logic [3:0] len);
      i_cmd_len = len; i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic setPhase(input logic msg, input logic cd, input logic io);
      i_msg = msg; i_cd = cd; i_io = io;
   endtask

   // One COMMAND byte: ACK rises with the byte, falls one cycle after REQ drops.
   task automatic cmdByte(input string tag, input logic [7:0] exp);
      setPhase(1'b0, 1'b1, 1'b0);
      i_req = 1'b1;
      step();
      check({tag, "_ack"}, o_ack, 1'b1);
      check({tag, "_db"}, o_db, exp);
      i_req = 1'b0;
      step();
      check({tag, "_rel"}, o_ack, 1'b0);
   endtask

   // One STATUS or MESSAGE_IN byte, returning the handshake to XFER.
   task automatic inByte(input string tag, input logic msg, input logic [7:0] db);
      setPhase(msg, 1'b1, 1'b1);
      i_db = db; i_req = 1'b1;
      step();
      check({tag, "_ack"}, o_ack, 1'b1);
      i_req = 1'b0;
      step();
      check({tag, "_rel"}, o_ack, 1'b0);
   endtask

   // Follows o_rst until it falls; it must be high exactly RST_CYCLES cycles.
   task automatic rstWatch(input string tag);
      int  cnt     = 1;
      bit  sawDone = 1'b0;
      for (int i = 0; i < 3 * RST_CYCLES && o_rst; i++) begin
         step();
         if (o_done) sawDone = 1'b1;
         if (o_rst) cnt++;
      end
      check({tag, "_rstlen"}, cnt, RST_CYCLES);
      check({tag, "_nodone"}, sawDone, 1'b0);
      check({tag, "_busy"}, o_busy, 1'b0);
   endtask

   logic [7:0] cmdBytes [6] = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00};

   initial begin
      i_rst_n = 1'b0; i_wr = 1'b0; i_wr_addr = 4'd0; i_wr_data = 8'h00;
      i_cmd_len = 4'd0; i_start = 1'b0; i_abort = 1'b0;
      i_bsy = 1'b0; i_req = 1'b0; i_msg = 1'b0; i_cd = 1'b0; i_io = 1'b0;
      i_db = 8'h00; i_din_ready = 1'b0;
      #12;
      check("reset_outputs", {o_db, o_sel, o_ack, o_rst, o_din_valid, o_din_data, o_busy,
                              o_done, o_status, o_message, o_timeout}, 64'd0);
      i_rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++) writeBuf(4'(i), cmdBytes[i]);

      // Six-byte command, one overrun byte, then status and message.
      startCmd(4'd6);
      check("start_sel", o_sel, 1'b1);
      check("start_busy", o_busy, 1'b1);
      check("start_timeout", o_timeout, 1'b0);
      i_bsy = 1'b1;
      step();
      check("bsy_sel_drop", o_sel, 1'b0);
      for (int i = 0; i < 6; i++) cmdByte($sformatf("cmd%0d", i), cmdBytes[i]);
      cmdByte("cmd_overrun", 8'h00);
      inByte("status0", 1'b0, 8'h00);
      check("status0_val", o_status, 8'h00);
      inByte("msg0", 1'b1, 8'h00);
      check("msg0_val", o_message, 8'h00);
      i_bsy = 1'b0;
      step();
      check("end0_done", o_done, 1'b1);
      check("end0_busy", o_busy, 1'b0);
      step();
      check("end0_done_pulse", o_done, 1'b0);

      // One-byte command then four data-in bytes with backpressure.
      startCmd(4'd1);
      i_bsy = 1'b1;
      step();
      cmdByte("len1", 8'h08);
      for (int j = 0; j < 4; j++) begin
         setPhase(1'b0, 1'b0, 1'b1);
         i_db = 8'hA1 + 8'(j); i_req = 1'b1; i_din_ready = 1'b0;
         step();
         check($sformatf("din%0d_valid", j), o_din_valid, 1'b1);
         check($sformatf("din%0d_data", j), o_din_data, 8'hA1 + 8'(j));
         check($sformatf("din%0d_noack", j), o_ack, 1'b0);
         i_db = 8'h5A;
         for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("din%0d_w%0d_valid", j, k), o_din_valid, 1'b1);
            check($sformatf("din%0d_w%0d_data", j, k), o_din_data, 8'hA1 + 8'(j));
            check($sformatf("din%0d_w%0d_noack", j, k), o_ack, 1'b0);
         end
         i_din_ready = 1'b1;
         step();
         check($sformatf("din%0d_ack", j), o_ack, 1'b1);
         check($sformatf("din%0d_vdrop", j), o_din_valid, 1'b0);
         i_din_ready = 1'b0; i_req = 1'b0;
         step();
         check($sformatf("din%0d_rel", j), o_ack, 1'b0);
      end
      inByte("status1", 1'b0, 8'h02);
      check("status1_val", o_status, 8'h02);
      inByte("msg1", 1'b1, 8'h80);
      check("msg1_val", o_message, 8'h80);
      check("db_held", o_db, 8'h08);
      i_bsy = 1'b0;
      step();
      check("end1_done", o_done, 1'b1);

      // Longest legal command, drive drops BSY before any message byte.
      startCmd(4'd12);
      check("len12_busy", o_busy, 1'b1);
      i_bsy = 1'b1;
      step();
      i_bsy = 1'b0;
      step();
      check("early_done", o_done, 1'b1);
      check("early_status", o_status, 8'h02);
      check("early_msg", o_message, 8'h80);

      // Length 13 is illegal and must not start anything.
      startCmd(4'd13);
      check("len13_busy", o_busy, 1'b0);
      check("len13_sel", o_sel, 1'b0);

      // Abort during the fourth command byte.
      startCmd(4'd6);
      i_bsy = 1'b1;
      step();
      for (int i = 0; i < 3; i++) cmdByte($sformatf("ab_cmd%0d", i), cmdBytes[i]);
      setPhase(1'b0, 1'b1, 1'b0);
      i_req = 1'b1;
      step();
      check("ab_cmd3_ack", o_ack, 1'b1);
      i_abort = 1'b1;
      step();
      i_abort = 1'b0; i_req = 1'b0; i_bsy = 1'b0;
      check("abort_ack", o_ack, 1'b0);
      check("abort_rst", o_rst, 1'b1);
      check("abort_sel", o_sel, 1'b0);
      rstWatch("abort");

      // Abort and start together in IDLE: abort wins.
      i_cmd_len = 4'd4; i_start = 1'b1; i_abort = 1'b1;
      step();
      i_start = 1'b0; i_abort = 1'b0;
      check("prio_rst", o_rst, 1'b1);
      check("prio_sel", o_sel, 1'b0);
      rstWatch("prio");

      // Asynchronous reset while ACK is held, then a zero-length start.
      startCmd(4'd2);
      i_bsy = 1'b1;
      step();
      setPhase(1'b0, 1'b1, 1'b0);
      i_req = 1'b1;
      step();
      check("hold_ack", o_ack, 1'b1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {o_db, o_sel, o_ack, o_rst, o_din_valid, o_din_data, o_busy,
                                    o_done, o_status, o_message, o_timeout}, 64'd0);
      i_req = 1'b0; i_bsy = 1'b0;
      #1;
      i_rst_n = 1'b1;
      step();
      startCmd(4'd0);
      check("len0_busy", o_busy, 1'b0);
      check("len0_sel", o_sel, 1'b0);

`ifdef CD_INITIATOR_SEL_TIMEOUT_EN
      // Selection with no BSY response gives up after SEL_TIMEOUT cycles.
      begin
         int selCycles = 1;
         startCmd(4'd1);
         for (int i = 0; i < 3 * SEL_TIMEOUT && o_sel; i++) begin
            step();
            if (o_sel) selCycles++;
            else begin
               check("to_done", o_done, 1'b1);
               check("to_flag", o_timeout, 1'b1);
            end
         end
         check("to_sel_len", selCycles, SEL_TIMEOUT);
         check("to_busy", o_busy, 1'b0);
      end
`else
      check("no_timeout_flag", o_timeout, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
